// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmitter and receiver on this link.
package uart_pkg;

  localparam int UART_DATA_W          = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 20;

  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_START   = 3'b001,
    S_DATA    = 3'b010,
    S_STOP    = 3'b011,
    S_CLEANUP = 3'b111
  } uart_state_t;

  // Baud counter width: never narrower than one bit, even for tiny divisors.
  function automatic int cnt_width(input int clks_per_bit);
    return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small first-word-fall-through FIFO feeding the UART serialiser.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   DEPTH_C = DEPTH[PTR_W:0];
  localparam logic [PTR_W:0]   CNT_ONE = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic [PTR_W:0]   count_next;
  logic             push;
  logic             pop;

  // Flags come from the registered count only, so a pop never frees a slot in the same cycle.
  assign full    = (count_reg == DEPTH_C);
  assign empty   = (count_reg == '0);
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr_reg];

  always_comb begin
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + CNT_ONE;
    end else if (pop && !push) begin
      count_next = count_reg - CNT_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      count_reg <= count_next;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: handshake into a FIFO, then LSB-first serialisation on an idle-high line.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   i_valid,
  input  logic [UART_DATA_W-1:0] i_Byte,
  output logic                   o_ready,
  output logic                   serial_out,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam int CNT_W = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  uart_state_t            state_reg;
  uart_state_t            state_next;
  logic [CNT_W-1:0]       clock_count_reg;
  logic [CNT_W-1:0]       clock_count_next;
  logic [2:0]             bit_index_reg;
  logic [2:0]             bit_index_next;
  logic [2:0]             bit_index_inc;
  logic [UART_DATA_W-1:0] tx_byte_reg;
  logic [UART_DATA_W-1:0] tx_byte_next;
  logic                   serial_reg;
  logic                   serial_next;
  logic                   done_reg;
  logic                   done_next;
  logic                   busy_reg;
  logic                   count_last;

  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [UART_DATA_W-1:0] fifo_data;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_W)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (i_valid),
    .wr_data (i_Byte),
    .rd_en   (fifo_pop),
    .rd_data (fifo_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign o_ready       = !fifo_full;
  assign serial_out    = serial_reg;
  assign o_done        = done_reg;
  assign o_busy        = busy_reg;
  assign count_last    = (clock_count_reg == CNT_LAST);
  assign bit_index_inc = bit_index_reg + 3'd1;

  always_comb begin
    state_next       = state_reg;
    clock_count_next = clock_count_reg;
    bit_index_next   = bit_index_reg;
    tx_byte_next     = tx_byte_reg;
    serial_next      = serial_reg;
    done_next        = 1'b0;
    fifo_pop         = 1'b0;

    case (state_reg)
      S_IDLE: begin
        serial_next      = 1'b1;
        clock_count_next = '0;
        bit_index_next   = '0;
        if (!fifo_empty) begin
          fifo_pop     = 1'b1;
          tx_byte_next = fifo_data;
          serial_next  = 1'b0;
          state_next   = S_START;
        end
      end

      S_START: begin
        if (count_last) begin
          clock_count_next = '0;
          serial_next      = tx_byte_reg[0];
          state_next       = S_DATA;
        end else begin
          clock_count_next = clock_count_reg + CNT_ONE;
        end
      end

      S_DATA: begin
        if (count_last) begin
          clock_count_next = '0;
          if (bit_index_reg == 3'd7) begin
            bit_index_next = '0;
            serial_next    = 1'b1;
            state_next     = S_STOP;
          end else begin
            bit_index_next = bit_index_inc;
            serial_next    = tx_byte_reg[bit_index_inc];
          end
        end else begin
          clock_count_next = clock_count_reg + CNT_ONE;
        end
      end

      S_STOP: begin
        serial_next = 1'b1;
        if (count_last) begin
          clock_count_next = '0;
          done_next        = 1'b1;
          state_next       = S_CLEANUP;
        end else begin
          clock_count_next = clock_count_reg + CNT_ONE;
        end
      end

      S_CLEANUP: begin
        serial_next = 1'b1;
        state_next  = S_IDLE;
      end

      // Unused encodings recover to a quiet line.
      default: begin
        serial_next      = 1'b1;
        clock_count_next = '0;
        bit_index_next   = '0;
        state_next       = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg       <= S_IDLE;
      clock_count_reg <= '0;
      bit_index_reg   <= '0;
      tx_byte_reg     <= '0;
      serial_reg      <= 1'b1;
      done_reg        <= 1'b0;
      busy_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      clock_count_reg <= clock_count_next;
      bit_index_reg   <= bit_index_next;
      tx_byte_reg     <= tx_byte_next;
      serial_reg      <= serial_next;
      done_reg        <= done_next;
      // Registered view of activity: clears the cycle after the FSM settles in S_IDLE with nothing queued.
      busy_reg        <= (state_reg != S_IDLE) || !fifo_empty;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: a line decoder pops expected bytes queued at push time.
module tb_uart_tx;

  localparam int CPB = 20;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       i_valid = 1'b0;
  logic [7:0] i_Byte = 8'h00;
  logic       o_ready;
  logic       serial_out;
  logic       o_busy;
  logic       o_done;

  uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .i_valid    (i_valid),
    .i_Byte     (i_Byte),
    .o_ready    (o_ready),
    .serial_out (serial_out),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [7:0] exp_q[$];
  int         frame_cnt = 0;
  int         done_cnt = 0;
  int         last_start = 0;
  int         prev_start = 0;
  int         accept_cyc = 0;

  int         mon_active = 0;
  int         mon_cnt = 0;
  int         mon_k = 0;
  logic [7:0] mon_byte = 8'h00;
  logic [7:0] mon_exp = 8'h00;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  initial begin
    forever begin
      @(posedge clock);
      cyc++;
    end
  end

  // Line decoder: samples each bit at its centre; a reset abandons any frame in progress.
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        mon_active = 0;
      end else begin
        if (o_done) done_cnt++;
        if (mon_active == 0) begin
          if (serial_out == 1'b0) begin
            mon_active = 1;
            mon_cnt    = 0;
            prev_start = last_start;
            last_start = cyc;
          end
        end else begin
          mon_cnt++;
          if (mon_cnt >= CPB / 2 && ((mon_cnt - CPB / 2) % CPB) == 0) begin
            mon_k = (mon_cnt - CPB / 2) / CPB;
            if (mon_k == 0) begin
              check_val("start_bit", serial_out, 0);
            end else if (mon_k <= 8) begin
              mon_byte = {serial_out, mon_byte[7:1]};
            end else begin
              check_val("stop_bit", serial_out, 1);
              frame_cnt++;
              check_val("sb_pending", exp_q.size() > 0, 1);
              if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                check_val("rx_byte", mon_byte, mon_exp);
                $display("frame %0d: rx 0x%02h expected 0x%02h start_cycle %0d", frame_cnt, mon_byte, mon_exp, last_start);
              end
              mon_active = 0;
            end
          end
        end
      end
    end
  end

  // Waits for space, offers one byte for one edge; track=0 means the byte is expected to be discarded.
  task automatic send(input logic [7:0] b, input bit track);
    int waited = 0;
    while (!o_ready && waited < 1000) begin
      @(posedge clock); #1;
      waited++;
    end
    check_val("ready_timeout", waited < 1000, 1);
    i_Byte  = b;
    i_valid = 1'b1;
    if (track) exp_q.push_back(b);
    @(posedge clock); #1;
    accept_cyc = cyc;
    i_valid = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frame_cnt < target && n < budget) begin
      @(posedge clock); #1;
      n++;
    end
    check_val("frames_seen", frame_cnt, target);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!o_done && n < budget) begin
      @(posedge clock); #1;
      n++;
    end
    check_val("done_timeout", n < budget, 1);
  endtask

  initial begin
    int f0;
    int d0;
    int n0;
    int lows;
    logic [7:0] rb;

    // Reset state
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check_val("rst_serial", serial_out, 1);
    check_val("rst_ready", o_ready, 1);
    check_val("rst_busy", o_busy, 0);
    check_val("rst_done", o_done, 0);
    reset = 1'b0;
    @(posedge clock); #1;

    // 1: single byte 0x55, exact latency and done/busy timing
    f0 = frame_cnt; d0 = done_cnt;
    send(8'h55, 1'b1);
    n0 = accept_cyc;
    wait_done(400);
    check_val("t1_done_cycle", cyc, n0 + 201);
    check_val("t1_start_cycle", last_start, n0 + 1);
    check_val("t1_busy_at_done", o_busy, 1);
    @(posedge clock); #1;
    check_val("t1_done_width", o_done, 0);
    check_val("t1_busy_cleanup", o_busy, 1);
    @(posedge clock); #1;
    check_val("t1_busy_idle", o_busy, 0);
    wait_frames(f0 + 1, 100);
    check_val("t1_done_count", done_cnt - d0, 1);

    // 2: back-to-back frames
    f0 = frame_cnt; d0 = done_cnt;
    send(8'hA5, 1'b1);
    send(8'h3C, 1'b1);
    wait_frames(f0 + 2, 600);
    check_val("t2_start_gap", last_start - prev_start, 202);
    repeat (20) @(posedge clock);
    #1;
    check_val("t2_done_count", done_cnt - d0, 2);

    // 3: hold i_valid for six cycles; 0x06 hits a full FIFO
    f0 = frame_cnt;
    i_valid = 1'b1;
    for (int b = 1; b <= 6; b++) begin
      i_Byte = 8'(b);
      if (b <= 5) exp_q.push_back(8'(b));
      @(posedge clock); #1;
      check_val("t3_ready", o_ready, b < 5);
    end
    i_valid = 1'b0;
    wait_frames(f0 + 5, 1200);
    repeat (20) @(posedge clock);
    #1;

    // 4: valid on the popping edge while full is refused; next push succeeds
    f0 = frame_cnt;
    send(8'h11, 1'b1);
    for (int b = 0; b < 4; b++) send(8'h21 + 8'(b), 1'b1);
    check_val("t4_full", o_ready, 0);
    wait_done(400);
    @(posedge clock); #1;
    check_val("t4_ready_before_pop", o_ready, 0);
    i_Byte  = 8'h99;
    i_valid = 1'b1;
    @(posedge clock); #1;
    i_valid = 1'b0;
    check_val("t4_ready_after_pop", o_ready, 1);
    send(8'h77, 1'b1);
    wait_frames(f0 + 6, 1500);
    repeat (20) @(posedge clock);
    #1;

    // 5: reset during data bit 3 of 0xF0 with two bytes queued
    f0 = frame_cnt; d0 = done_cnt;
    send(8'hF0, 1'b0);
    n0 = accept_cyc;
    send(8'h12, 1'b0);
    send(8'h34, 1'b0);
    while (cyc < n0 + 91) begin
      @(posedge clock); #1;
    end
    check_val("t5_bit3_low", serial_out, 0);
    reset = 1'b1;
    @(posedge clock); #1;
    check_val("t5_serial", serial_out, 1);
    check_val("t5_busy", o_busy, 0);
    check_val("t5_done", o_done, 0);
    check_val("t5_ready", o_ready, 1);
    reset = 1'b0;
    lows = 0;
    repeat (500) begin
      @(posedge clock); #1;
      if (!serial_out) lows++;
    end
    check_val("t5_line_quiet", lows, 0);
    check_val("t5_no_frames", frame_cnt - f0, 0);
    check_val("t5_no_done", done_cnt - d0, 0);
    check_val("t5_idle_busy", o_busy, 0);

    // 6: 256 random bytes through the loopback decoder
    f0 = frame_cnt; d0 = done_cnt;
    for (int i = 0; i < 256; i++) begin
      rb = 8'($urandom_range(0, 255));
      send(rb, 1'b1);
    end
    wait_frames(f0 + 256, 3000);
    repeat (20) @(posedge clock);
    #1;
    check_val("t6_done_vs_frames", done_cnt - d0, frame_cnt - f0);
    check_val("sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
